// File: rtl/cache_pkg.sv
// cache_pkg
// Shared types and widths for the memory-stage cache controller.
//   state_t : controller FSM states (IDLE, RD_MISS, WR_THRU)
//   TAG_W, INDEX_W : field widths of the cache word address
//   CADDR_W : cache word address width {tag, index, offset}
//   LINE_W  : width of one cache line (two 32-bit words)
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

  localparam int TAG_W   = 10;
  localparam int INDEX_W = 6;
  localparam int CADDR_W = TAG_W + INDEX_W + 1;
  localparam int LINE_W  = 64;

endpackage

// File: rtl/cache_controller.sv
// cache_controller
// Memory-stage controller between the pipeline MEM stage, a 2-way data cache
// and the SRAM controller. Read-allocate, write-through, no-write-allocate;
// a store invalidates any cached copy of its line.
// Ports:
//   clk, rst (async, active-low)
//   Pipeline : mem_r_en, mem_w_en, address, wdata -> rdata, ready
//   Cache    : cache_address, cache_read_en, cache_write_en, invalid,
//              cache_write_data  <- hit, cache_read_data
//   SRAM     : sram_r_en, sram_w_en, sram_address, sram_wdata
//              <- sram_rdata, sram_ready
module cache_controller
  import cache_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'd1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [31:0]         address,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [CADDR_W-1:0]  cache_address,
  output logic                cache_read_en,
  output logic                cache_write_en,
  output logic                invalid,
  output logic [LINE_W-1:0]   cache_write_data,
  input  logic                hit,
  input  logic [31:0]         cache_read_data,
  output logic                sram_r_en,
  output logic                sram_w_en,
  output logic [31:0]         sram_address,
  output logic [31:0]         sram_wdata,
  input  logic [LINE_W-1:0]   sram_rdata,
  input  logic                sram_ready
);

  logic [31:0] w_eff;
  state_t      r_state;
  logic [31:0] r_eff;
  logic [31:0] r_wdata;

  assign w_eff = address - ADDR_BASE;

  // State and request register. A store takes priority over a load issued in
  // the same cycle. Only a read miss or a store leaves IDLE; the latched copy
  // drives every output afterwards so the pipeline may change its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_eff   <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_w_en) begin
            r_state <= WR_THRU;
            r_eff   <= w_eff;
            r_wdata <= wdata;
          end else if (mem_r_en && !hit) begin
            r_state <= RD_MISS;
            r_eff   <= w_eff;
          end
        end
        RD_MISS: if (sram_ready) r_state <= IDLE;
        WR_THRU: if (sram_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so a read hit completes with zero stall. They
  // are forced to their idle values while reset is held, which also drops any
  // SRAM strobe the instant reset is asserted. Address outputs read zero when
  // nothing is being requested.
  always_comb begin
    rdata            = '0;
    ready            = 1'b1;
    cache_address    = '0;
    cache_read_en    = 1'b0;
    cache_write_en   = 1'b0;
    invalid          = 1'b0;
    cache_write_data = '0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    sram_address     = '0;
    sram_wdata       = '0;
    if (rst) begin
      case (r_state)
        IDLE: begin
          if (mem_w_en) begin
            invalid       = 1'b1;
            cache_address = w_eff[18:2];
            ready         = 1'b0;
          end else if (mem_r_en) begin
            cache_read_en = 1'b1;
            cache_address = w_eff[18:2];
            if (hit) rdata = cache_read_data;
            else     ready = 1'b0;
          end
        end
        RD_MISS: begin
          sram_r_en     = 1'b1;
          sram_address  = {r_eff[31:3], 3'b000};
          cache_address = r_eff[18:2];
          ready         = 1'b0;
          if (sram_ready) begin
            cache_read_en    = 1'b1;
            cache_write_en   = 1'b1;
            cache_write_data = sram_rdata;
            rdata            = r_eff[2] ? sram_rdata[63:32] : sram_rdata[31:0];
            ready            = 1'b1;
          end
        end
        WR_THRU: begin
          sram_w_en     = 1'b1;
          sram_address  = r_eff;
          sram_wdata    = r_wdata;
          cache_address = r_eff[18:2];
          ready         = sram_ready;
        end
        default: ready = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller
// Self-checking bench for cache_controller. A small behavioural cache model
// answers hit/cache_read_data; the SRAM side is driven cycle by cycle from the
// scenario tasks. Expected load data is queued when a load is issued and
// compared when the controller completes it.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [16:0] cache_address;
  logic        cache_read_en;
  logic        cache_write_en;
  logic        invalid;
  logic [63:0] cache_write_data;
  logic        hit;
  logic [31:0] cache_read_data;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [31:0] expQ[$];
  logic [31:0] expData;

  logic        clearCache;
  logic        cValid [0:65535];
  logic [63:0] cData  [0:65535];

  cache_controller #(.ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_read_en(cache_read_en),
    .cache_write_en(cache_write_en), .invalid(invalid),
    .cache_write_data(cache_write_data),
    .hit(hit), .cache_read_data(cache_read_data),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural cache: one line per {tag,index}, word chosen by the offset bit.
  always_comb begin
    hit             = cValid[cache_address[16:1]];
    cache_read_data = cache_address[0] ? cData[cache_address[16:1]][63:32]
                                       : cData[cache_address[16:1]][31:0];
  end

  always @(posedge clk) begin
    if (clearCache) begin
      for (int i = 0; i < 65536; i++) cValid[i] <= 1'b0;
    end else begin
      if (cache_read_en && cache_write_en) begin
        cValid[cache_address[16:1]] <= 1'b1;
        cData[cache_address[16:1]]  <= cache_write_data;
      end
      if (invalid) cValid[cache_address[16:1]] <= 1'b0;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
    sram_rdata = '0; sram_ready = 1'b0; clearCache = 1'b1;
    #1;
    testsRun++;
    if (ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %0b expected 1", ready); end
    testsRun++;
    if ({cache_read_en, cache_write_en, invalid, sram_r_en, sram_w_en} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_strobes: got %05b expected 00000",
               {cache_read_en, cache_write_en, invalid, sram_r_en, sram_w_en});
    end
    testsRun++;
    if (rdata !== 32'd0 || cache_address !== 17'd0 || cache_write_data !== 64'd0 ||
        sram_address !== 32'd0 || sram_wdata !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got rdata=%h caddr=%h cwd=%h saddr=%h swd=%h expected all 0",
               rdata, cache_address, cache_write_data, sram_address, sram_wdata);
    end
    nextCycle();
    clearCache = 1'b0;
    nextCycle();
    rst = 1'b1;
    nextCycle();
  endtask

  task automatic test_cold_miss();
    int stalls = 0;
    address = 32'd1032; mem_r_en = 1'b1;
    expQ.push_back(32'hAAAA_AAAA);
    #1;
    testsRun++;
    if (cache_read_en !== 1'b1 || cache_address !== 17'd2) begin
      testsFailed++;
      $display("[TB] FAIL miss_lookup: got rd_en=%0b caddr=%0d expected 1/2", cache_read_en, cache_address);
    end
    if (ready === 1'b0) stalls++;
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      if (ready === 1'b0) stalls++;
      testsRun++;
      if (sram_r_en !== 1'b1 || sram_address !== 32'd8 || sram_w_en !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL miss_sram_req: got r_en=%0b w_en=%0b addr=%0d expected 1/0/8",
                 sram_r_en, sram_w_en, sram_address);
      end
    end
    nextCycle();
    sram_ready = 1'b1; sram_rdata = 64'hBBBB_BBBB_AAAA_AAAA;
    #1;
    if (ready === 1'b0) stalls++;
    testsRun++;
    if (cache_read_en !== 1'b1 || cache_write_en !== 1'b1 || ready !== 1'b1 ||
        cache_write_data !== 64'hBBBB_BBBB_AAAA_AAAA || cache_address !== 17'd2) begin
      testsFailed++;
      $display("[TB] FAIL miss_fill: got rd=%0b wr=%0b rdy=%0b cwd=%h caddr=%0d expected 1/1/1/BBBBBBBBAAAAAAAA/2",
               cache_read_en, cache_write_en, ready, cache_write_data, cache_address);
    end
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++; $display("[TB] FAIL miss_rdata: got unexpected completion, expected none");
    end else begin
      expData = expQ.pop_front();
      if (rdata !== expData) begin
        testsFailed++; $display("[TB] FAIL miss_rdata: got %h expected %h", rdata, expData);
      end
    end
    testsRun++;
    if (stalls != 3) begin testsFailed++; $display("[TB] FAIL miss_stall: got %0d expected 3", stalls); end
    nextCycle();
    mem_r_en = 1'b0; sram_ready = 1'b0;
    nextCycle();
  endtask

  task automatic test_read_hit();
    logic [31:0] addrs [2];
    logic [31:0] datas [2];
    addrs[0] = 32'd1036; datas[0] = 32'hBBBB_BBBB;
    addrs[1] = 32'd1032; datas[1] = 32'hAAAA_AAAA;
    for (int k = 0; k < 2; k++) begin
      address = addrs[k]; mem_r_en = 1'b1;
      expQ.push_back(datas[k]);
      #1;
      testsRun++;
      if (ready !== 1'b1 || sram_r_en !== 1'b0 || cache_read_en !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL hit_status[%0d]: got rdy=%0b sram_r=%0b rd_en=%0b expected 1/0/1",
                 k, ready, sram_r_en, cache_read_en);
      end
      testsRun++;
      expData = expQ.pop_front();
      if (rdata !== expData) begin
        testsFailed++; $display("[TB] FAIL hit_rdata[%0d]: got %h expected %h", k, rdata, expData);
      end
      nextCycle();
    end
    mem_r_en = 1'b0;
    #1;
    testsRun++;
    if (sram_r_en !== 1'b0) begin testsFailed++; $display("[TB] FAIL hit_no_sram: got %0b expected 0", sram_r_en); end
    nextCycle();
  endtask

  task automatic test_write_through();
    address = 32'd1032; wdata = 32'h0000_1234; mem_w_en = 1'b1;
    #1;
    testsRun++;
    if (invalid !== 1'b1 || cache_address !== 17'd2 || ready !== 1'b0 || cache_read_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wr_accept: got inv=%0b caddr=%0d rdy=%0b rd_en=%0b expected 1/2/0/0",
               invalid, cache_address, ready, cache_read_en);
    end
    nextCycle();
    testsRun++;
    if (invalid !== 1'b0 || sram_w_en !== 1'b1 || sram_r_en !== 1'b0 ||
        sram_address !== 32'd8 || sram_wdata !== 32'h0000_1234 || ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wr_sram: got inv=%0b w=%0b r=%0b addr=%0d data=%h rdy=%0b expected 0/1/0/8/00001234/0",
               invalid, sram_w_en, sram_r_en, sram_address, sram_wdata, ready);
    end
    nextCycle();
    sram_ready = 1'b1;
    #1;
    testsRun++;
    if (ready !== 1'b1 || cache_write_en !== 1'b0 || invalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wr_done: got rdy=%0b cwr=%0b inv=%0b expected 1/0/0", ready, cache_write_en, invalid);
    end
    nextCycle();
    mem_w_en = 1'b0; sram_ready = 1'b0;
    nextCycle();
    address = 32'd1032; mem_r_en = 1'b1;
    expQ.push_back(32'h0000_1234);
    #1;
    testsRun++;
    if (ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL wr_then_miss: got rdy=%0b expected 0", ready); end
    nextCycle();
    testsRun++;
    if (sram_r_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL wr_then_sram_r: got %0b expected 1", sram_r_en); end
    nextCycle();
    sram_ready = 1'b1; sram_rdata = 64'hBBBB_BBBB_0000_1234;
    #1;
    testsRun++;
    expData = expQ.pop_front();
    if (rdata !== expData || ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL wr_then_rdata: got %h rdy=%0b expected %h rdy=1", rdata, ready, expData);
    end
    nextCycle();
    mem_r_en = 1'b0; sram_ready = 1'b0;
    nextCycle();
  endtask

  task automatic test_simultaneous();
    address = 32'd1040; wdata = 32'h5555_0000; mem_r_en = 1'b1; mem_w_en = 1'b1;
    #1;
    testsRun++;
    if (invalid !== 1'b1 || cache_read_en !== 1'b0 || cache_address !== 17'd4) begin
      testsFailed++;
      $display("[TB] FAIL rw_accept: got inv=%0b rd_en=%0b caddr=%0d expected 1/0/4", invalid, cache_read_en, cache_address);
    end
    nextCycle();
    testsRun++;
    if (sram_w_en !== 1'b1 || sram_r_en !== 1'b0 || sram_address !== 32'd16 ||
        sram_wdata !== 32'h5555_0000 || cache_read_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rw_sram: got w=%0b r=%0b addr=%0d data=%h rd_en=%0b expected 1/0/16/55550000/0",
               sram_w_en, sram_r_en, sram_address, sram_wdata, cache_read_en);
    end
    nextCycle();
    sram_ready = 1'b1;
    #1;
    testsRun++;
    if (ready !== 1'b1 || cache_read_en !== 1'b0 || cache_write_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rw_done: got rdy=%0b rd_en=%0b cwr=%0b expected 1/0/0", ready, cache_read_en, cache_write_en);
    end
    nextCycle();
    mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset_mid_miss();
    address = 32'd1048; mem_r_en = 1'b1;
    nextCycle();
    testsRun++;
    if (sram_r_en !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_pre: got sram_r=%0b expected 1", sram_r_en); end
    #2;
    rst = 1'b0;
    #1;
    testsRun++;
    if (sram_r_en !== 1'b0 || ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL rst_async: got sram_r=%0b rdy=%0b expected 0/1", sram_r_en, ready);
    end
    nextCycle();
    mem_r_en = 1'b0;
    nextCycle();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sram_ready = (c == 1);
      sram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      testsRun++;
      if (cache_write_en !== 1'b0 || cache_read_en !== 1'b0 || sram_r_en !== 1'b0 || ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL rst_no_fill[%0d]: got cwr=%0b crd=%0b sram_r=%0b rdy=%0b expected 0/0/0/1",
                 c, cache_write_en, cache_read_en, sram_r_en, ready);
      end
      nextCycle();
    end
    sram_ready = 1'b0;
  endtask

  task automatic test_stale_input();
    address = 32'd1056; mem_r_en = 1'b1;
    expQ.push_back(32'hCCCC_CCCC);
    nextCycle();
    address = 32'd2000;
    for (int c = 0; c < 2; c++) begin
      #1;
      testsRun++;
      if (sram_address !== 32'd32 || cache_address !== 17'd8) begin
        testsFailed++;
        $display("[TB] FAIL stale_addr[%0d]: got saddr=%0d caddr=%0d expected 32/8", c, sram_address, cache_address);
      end
      nextCycle();
    end
    sram_ready = 1'b1; sram_rdata = 64'hDDDD_DDDD_CCCC_CCCC;
    #1;
    testsRun++;
    expData = expQ.pop_front();
    if (rdata !== expData || cache_address !== 17'd8 || cache_write_en !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL stale_fill: got rdata=%h caddr=%0d cwr=%0b expected %h/8/1",
               rdata, cache_address, cache_write_en, expData);
    end
    nextCycle();
    mem_r_en = 1'b0; sram_ready = 1'b0;
    nextCycle();
    address = 32'd1060; mem_r_en = 1'b1;
    expQ.push_back(32'hDDDD_DDDD);
    #1;
    testsRun++;
    expData = expQ.pop_front();
    if (rdata !== expData || ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL stale_hit: got %h rdy=%0b expected %h rdy=1", rdata, ready, expData);
    end
    nextCycle();
    mem_r_en = 1'b0;
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_read_hit();
    test_write_through();
    test_simultaneous();
    test_reset_mid_miss();
    test_stale_input();
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Memory-stage controller that sits between the pipeline's MEM stage, the 2-way data cache and the SRAM controller. It owns the cache's command side and issues `cache_read_en`, `cache_write_en`, `invalid` and the 64-bit line to install. It also decides hit/miss handling: read-allocate, write-through and no-write-allocate. A write invalidates any cached copy of its line. The pipeline is stalled through `ready` while the SRAM controller is busy.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte offset subtracted from the pipeline address before mapping.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `mem_r_en`  in  1  pipeline load request.
- `mem_w_en`  in  1  pipeline store request.
- `address`  in  32  pipeline byte address.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid when `ready` is high with a load.
- `ready`  out  1  request complete (or no request); low means freeze the pipeline.
- `cache_address`  out  17  cache word address, `{tag[9:0], index[5:0], offset}`.
- `cache_read_en`  out  1  cache lookup strobe, which updates LRU on a hit.
- `cache_write_en`  out  1  line fill; only meaningful together with `cache_read_en` on a miss.
- `invalid`  out  1  invalidate the matching way of `cache_address`.
- `cache_write_data`  out  64  line to install; `[31:0]` is word 0, `[63:32]` is word 1.
- `hit`  in  1  cache hit, combinational from `cache_address`.
- `cache_read_data`  in  32  cache word on a hit.
- `sram_r_en`  out  1  SRAM line read request, held until `sram_ready`.
- `sram_w_en`  out  1  SRAM word write request, held until `sram_ready`.
- `sram_address`  out  32  SRAM byte address (effective address).
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  64  SRAM line, valid with `sram_ready`.
- `sram_ready`  in  1  SRAM transaction done; a one-cycle pulse.

## Operation
- Effective address `eff = address - ADDR_BASE`.
- Mapping:
  - `cache_address = eff[18:2]`.
  - For reads, `sram_address = {eff[31:3], 3'b0}` (line-aligned).
  - For writes, `sram_address = eff`.
- Request register: the address and wdata are latched when a request is accepted in IDLE. All outputs in the non-IDLE states use the latched values.
- FSM states are IDLE, RD_MISS and WR_THRU.
  - IDLE with `mem_w_en`: drive `invalid=1` for this cycle, latch the request, go to WR_THRU.
  - IDLE with `mem_r_en` and no `mem_w_en`: drive `cache_read_en=1`.
    - If `hit`: `rdata = cache_read_data`, `ready=1`, stay in IDLE.
    - If not `hit`: latch the request, go to RD_MISS.
  - IDLE with no request: `ready=1`, all strobes low.
  - RD_MISS: hold `sram_r_en=1`. On the `sram_ready` cycle:
    - drive `cache_read_en=1`, `cache_write_en=1` and `cache_write_data = sram_rdata`;
    - drive `rdata = offset ? sram_rdata[63:32] : sram_rdata[31:0]` and `ready=1`;
    - go to IDLE.
  - WR_THRU: hold `sram_w_en=1` with `sram_wdata` set to the latched wdata. On `sram_ready`, drive `ready=1` and go to IDLE.
- `mem_r_en` and `mem_w_en` asserted together: the write path is taken and the read is ignored.
- Request inputs that change while not in IDLE are ignored, because the latched copy is used.
- `sram_ready` seen in IDLE is ignored.

## Timing
- Reset values of all outputs:
  - `ready`: 1.
  - `rdata`, `cache_address`, `cache_write_data`, `sram_address`, `sram_wdata`: 0.
  - All strobes: 0.
  - State: IDLE.
- Read hit: zero stall. `ready` is combinational in the request cycle.
- Read miss: `ready` goes high in the same cycle as `sram_ready`. The fill strobe is asserted in that same cycle, and the line is visible to the next lookup one cycle later.
- Write: `invalid` is asserted for exactly one cycle, the accept cycle. `ready` goes high in the `sram_ready` cycle.
- Next request: the earliest is the cycle after `ready`. Back-to-back read hits proceed at one per cycle.
- Reset mid-operation: the FSM returns to IDLE and SRAM strobes drop immediately. No fill or invalidate is issued, and the pending SRAM transaction is abandoned.
- `sram_r_en` and `sram_w_en` are never high together. Cache strobes are never asserted outside the cases above.

## Structure
- Package `cache_pkg` holds:
  - the state enum `{IDLE, RD_MISS, WR_THRU}`;
  - widths `TAG_W=10`, `INDEX_W=6`, `CADDR_W=17`, `LINE_W=64`.
- Single module; the FSM and request register are inline. No sub-module is warranted.

## Test plan
All scenarios use `ADDR_BASE=1024`.
- **Cold read miss:** read 1032, and the SRAM model answers after 3 cycles with `sram_rdata = 64'hBBBB_BBBB_AAAA_AAAA`.
  - `sram_address` is 8 and `cache_address` is 2.
  - In the fill cycle: `cache_read_en=1`, `cache_write_en=1`, `rdata = 32'hAAAA_AAAA`, `ready=1`.
  - Total stall is 3 cycles.
- **Read hit:** following the cold miss, read 1036.
  - `rdata = 32'hBBBB_BBBB` with `ready=1` in the same cycle.
  - `sram_r_en` stays 0.
- **Write-through:** write 1032 with `wdata = 32'h0000_1234`.
  - `invalid=1` for one cycle.
  - `sram_w_en` with address 8 and data `32'h1234`; `ready` goes high on `sram_ready`.
  - A subsequent read of 1032 misses and issues `sram_r_en`.
- **Simultaneous read and write:** assert `mem_r_en` and `mem_w_en` at 1040.
  - The WR_THRU path is taken.
  - No `cache_read_en` and no `sram_r_en`.
- **Reset mid-miss:** assert `rst=0` while in RD_MISS.
  - `sram_r_en` drops asynchronously and `ready=1`.
  - No fill strobe appears after reset is released.
- **Stale input during stall:** change `address` while in RD_MISS.
  - `sram_address`, `cache_address` and the fill still use the latched address.
